// File: rtl/lfo_pkg.sv
// lfo_pkg: shared state encoding and sizing constants for the vibrato LFO
package lfo_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PARK} state_t;
  localparam int PHASE_W = 24;
  localparam int LUT_AW = 6;
  localparam int OUT_W = 10;
  localparam int OUT_MID = 512;
endpackage

// File: rtl/sine_quarter_rom.sv
// sine_quarter_rom: 64-entry quarter-wave table, round(511*sin(pi/2*(i+0.5)/64))
module sine_quarter_rom (
  input  logic [5:0] addr,
  output logic [8:0] q
);
  localparam logic [8:0] ROM [64] = '{
    9'd6,   9'd19,  9'd31,  9'd44,  9'd56,  9'd69,  9'd81,  9'd94,
    9'd106, 9'd118, 9'd130, 9'd142, 9'd154, 9'd166, 9'd178, 9'd190,
    9'd201, 9'd213, 9'd224, 9'd235, 9'd246, 9'd257, 9'd268, 9'd279,
    9'd289, 9'd299, 9'd309, 9'd319, 9'd329, 9'd338, 9'd348, 9'd357,
    9'd366, 9'd374, 9'd383, 9'd391, 9'd399, 9'd407, 9'd414, 9'd421,
    9'd428, 9'd435, 9'd441, 9'd448, 9'd454, 9'd459, 9'd465, 9'd470,
    9'd474, 9'd479, 9'd483, 9'd487, 9'd491, 9'd494, 9'd497, 9'd500,
    9'd502, 9'd505, 9'd506, 9'd508, 9'd509, 9'd510, 9'd511, 9'd511
  };
  assign q = ROM[addr];
endmodule

// File: rtl/vibrato_lfo.sv
// vibrato_lfo: per-frame phase accumulator driving a depth-scaled sine/triangle modulation value
module vibrato_lfo import lfo_pkg::*; #(
  parameter int PHASE_W = lfo_pkg::PHASE_W,
  parameter int LUT_AW = lfo_pkg::LUT_AW,
  parameter int OUT_W = lfo_pkg::OUT_W
) (
  input  logic        ADCLRCK,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] rate,
  input  logic [9:0]  depth,
  input  logic        shape,
  output logic [31:0] sin,
  output logic        sin_update,
  output logic        phase_wrap
);
  state_t state, state_nx;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W:0] sum;
  logic [1:0] quad;
  logic [LUT_AW-1:0] idx;
  logic [8:0] q;
  logic [OUT_W-1:0] sine_u, tri_u, wave_u, sin_q, sin_nx;
  logic [9:0] depth_active;
  logic [OUT_W+9:0] prod;
  logic active, wrap;
  assign active = state != IDLE;
  assign sum = {1'b0, phase} + (PHASE_W+1)'(rate);
  assign wrap = sum[PHASE_W];
  assign quad = phase[PHASE_W-1 -: 2];
  assign idx = quad[0] ? ~phase[PHASE_W-3 -: LUT_AW] : phase[PHASE_W-3 -: LUT_AW];
  sine_quarter_rom u_rom (.addr(idx), .q(q));
  assign sine_u = quad[1] ? OUT_W'(OUT_MID) - OUT_W'(q) : OUT_W'(OUT_MID) + OUT_W'(q);
  assign tri_u = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: OUT_W] : phase[PHASE_W-2 -: OUT_W];
  assign prod = wave_u * depth_active;
  assign sin_nx = prod[OUT_W+9 -: OUT_W];
  assign sin = 32'(sin_q);
  // a wrap while parked ends the cycle even if enable has come back
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (enable ? RUN : IDLE) :
               (state == RUN)  ? (enable ? RUN : PARK) :
               wrap ? IDLE : (enable ? RUN : PARK);
  end
  always_ff @(posedge ADCLRCK or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge ADCLRCK or posedge rst)
    if (rst) begin
      phase <= '0;
      wave_u <= '0;
      sin_q <= '0;
      depth_active <= '0;
      sin_update <= 1'b0;
      phase_wrap <= 1'b0;
    end else begin
      phase_wrap <= active & wrap;
      sin_update <= active & (sin_nx != sin_q);
      if (active) begin
        phase <= (state == PARK && wrap) ? '0 : sum[PHASE_W-1:0];
        wave_u <= shape ? tri_u : sine_u;
        sin_q <= sin_nx;
      end
      if (!active || wrap) depth_active <= depth;
    end
endmodule
